sr_multi_rw: RTL and testbench
==============================

# sr_multi_rw

Multi-chain shift-register read/write engine for TMII-family ASIC configuration. It shifts NCHAIN independent serial chains in lockstep from a shared divided-clock tick and captures the bits each chain shifts back out. It then pulses a shared load strobe and makes the captured data available as 16-bit words through a readback port. It sits between the control-interface register/FIFO logic and the differential I/O buffers, which stay outside this block.

## Interface
- WIDTH, 170, bits per chain (1..2**CNT_WIDTH-1)
- CNT_WIDTH, 8, bit-counter width
- NCHAIN, 2, number of parallel chains (1..8)
- DIV_WIDTH, 6, width of div input
- SHIFT_DIRECTION, 1, 1: bit WIDTH-1 shifted out first; 0: bit 0 first
- NWORD (derived, not overridable), ceil(WIDTH/16), 16-bit words per chain
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- div  in  DIV_WIDTH  tick period = 2**div clk cycles; sampled on accepted start
- cfg_wr_en  in  1  write cfg_din into TX buffer of chain cfg_sel
- cfg_sel  in  3  target chain for cfg writes
- cfg_din  in  16  configuration word
- start  in  1  begin a shift/load cycle
- busy  out  1  cycle in progress
- done  out  1  one-clk pulse at end of cycle
- sr_clk  out  1  shift clock to chip
- sr_dout  out  NCHAIN  serial data to chips
- sr_din  in  NCHAIN  serial data from chips
- sr_load  out  1  load strobe to chips
- rd_en  in  1  request next readback word
- rd_data  out  16  readback word
- rd_valid  out  1  rd_data valid, one clk

## Operation
- Reset values: busy=0, done=0, sr_clk=0, sr_dout=0, sr_load=0, rd_data=0, rd_valid=0. TX and RX buffers are zero. All pointers are 0. State is IDLE.
- TX write:
  - cfg_wr_en in IDLE writes cfg_din to TX[cfg_sel] word wptr[cfg_sel]. Word k covers bits [16k+15:16k].
  - Bits at or above WIDTH are dropped.
  - wptr saturates at NWORD-1, so further writes overwrite the last word.
  - Writes with cfg_sel >= NCHAIN, or while busy, are ignored.
- FSM IDLE -> SHIFT -> LOAD -> FIN -> IDLE.
  - IDLE: start=1 latches div, clears the tick counter, sets busy=1 on the next clk, and enters SHIFT.
  - SHIFT: each bit uses two tick periods.
    - Phase 0: sr_clk=0 and sr_dout presents the current bit of each chain.
    - Phase 1: sr_clk=1.
    - On the tick ending phase 1, each sr_din[i] is shifted into RX[i] and the bit counter increments.
    - After WIDTH bits the FSM goes to LOAD.
  - LOAD: sr_load=1 and sr_clk=0 for one tick period; then FIN.
  - FIN: done=1 for one clk and busy=0 in the same clk. All wptr and rptr are cleared. Return to IDLE.
- RX ordering: after WIDTH captures, RX bit j equals the bit the chip held at position j. For SHIFT_DIRECTION=1 the first captured bit lands at WIDTH-1; for 0 it lands at 0.
- TX is not modified by shifting, so a repeated start re-sends the same configuration.
- Readback:
  - rd_en in IDLE returns word rptr. Order is chain 0 words 0..NWORD-1, then chain 1, and so on.
  - rptr wraps to 0 after the last word of chain NCHAIN-1.
  - Unused upper bits of the last word read as 0.
  - rd_en while busy is ignored: rd_valid stays 0 and the pointer does not move.
- start while busy is ignored. start and cfg_wr_en in the same IDLE cycle: the write completes first and is included in the shift.
- rst mid-cycle returns the block to reset values immediately. sr_load is never left high.

## Timing
- Tick asserts when the divider count equals 2**div-1. div=0 gives a tick every clk.
- start accepted at edge N: busy=1 from N+1. sr_dout holds bit 0 of the sequence from N+1.
- SHIFT lasts 2*WIDTH*2**div clks and LOAD lasts 2**div clks.
- done is high in clk N+1+(2*WIDTH+1)*2**div, and busy falls in that same clk.
- sr_dout changes only on the tick that drops sr_clk, giving a full tick period of setup and hold around each rising edge.
- Readback latency: rd_en at edge M gives rd_valid=1 and rd_data at M+1. Back-to-back rd_en gives one word per clk.
- div changes while busy have no effect until the next start.

## Test plan
- WIDTH=170, NCHAIN=2, div=0; write 11 words per chain (chain0 0xA5A5 pattern, chain1 0x0001..0x000B); loopback sr_dout->sr_din; start -> 170 sr_clk rising edges; done at start+342 clks; RX is 0 on the first run. A second start reads back exactly the written TX, bits 170..175 read 0.
- div=3, SHIFT_DIRECTION=0, single chain, TX=1 at bit 0 only -> sr_dout high only during the first 16 clks; sr_load high for exactly 8 clks; busy high for 341*8 clks.
- start and cfg_wr_en pulsed while busy -> no restart, TX unchanged, single done pulse. rd_en while busy -> rd_valid stays 0.
- rst asserted midway through SHIFT -> all outputs 0 the same clk. A following start completes normally with full latency.
- Readback wrap: 23 rd_en pulses with NCHAIN=2, NWORD=11 -> words chain0 w0..w10, chain1 w0..w10, then chain0 w0 again; rd_valid one clk after each rd_en.

Source files
------------

// File: rtl/sr_multi_rw.sv
`timescale 1ns/1ps
// Lockstep multi-chain shift/load engine with 16-bit readback of the captured bits.
// Cycle is (2*WIDTH+1)*2**div clks from start to done; start, cfg writes and reads are ignored while busy.
module sr_multi_rw #(
  parameter int WIDTH           = 170,
  parameter int CNT_WIDTH       = 8,
  parameter int NCHAIN          = 2,
  parameter int DIV_WIDTH       = 6,
  parameter int SHIFT_DIRECTION = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic                 cfg_wr_en,
  input  logic [2:0]           cfg_sel,
  input  logic [15:0]          cfg_din,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 sr_clk,
  output logic [NCHAIN-1:0]    sr_dout,
  input  logic [NCHAIN-1:0]    sr_din,
  output logic                 sr_load,
  input  logic                 rd_en,
  output logic [15:0]          rd_data,
  output logic                 rd_valid
);

  localparam int NWORD = (WIDTH + 15) / 16;
  localparam int TW    = NWORD * 16;
  localparam int TWP   = TW + 1;
  localparam int WPW   = (NWORD > 1) ? $clog2(NWORD) : 1;
  localparam int DCW   = 1 << DIV_WIDTH;
  localparam logic [TW:0]          ONE_AT_W = TWP'(1) << WIDTH;
  localparam logic [TW-1:0]        VMASK    = TW'(ONE_AT_W - 1'b1);
  localparam logic [CNT_WIDTH-1:0] LAST_BIT = CNT_WIDTH'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD, FIN} state_t;

  state_t                 state;
  logic [TW-1:0]          tx     [NCHAIN];
  logic [TW-1:0]          tx_nxt [NCHAIN];
  logic [TW-1:0]          rx     [NCHAIN];
  logic [WPW-1:0]         wptr   [NCHAIN];
  logic [2:0]             rchain;
  logic [WPW-1:0]         rword;
  logic [DIV_WIDTH-1:0]   div_q;
  logic [DCW-1:0]         div_cnt;
  logic                   tick;
  logic                   phase;
  logic [CNT_WIDTH-1:0]   bit_cnt;
  logic [15:0]            rd_word;

  // Position within the chain of the n-th bit on the wire; also where the n-th returned bit belongs.
  function automatic logic [CNT_WIDTH-1:0] bit_idx(input logic [CNT_WIDTH-1:0] n);
    return (SHIFT_DIRECTION != 0) ? LAST_BIT - n : n;
  endfunction

  assign tick = (div_cnt == ~({DCW{1'b1}} << div_q));

  // Write-through view of TX so a write coinciding with start feeds the very first bit.
  always_comb begin
    for (int c = 0; c < NCHAIN; c++) begin
      tx_nxt[c] = tx[c];
      for (int k = 0; k < NWORD; k++) begin
        if (state == IDLE && cfg_wr_en && cfg_sel == 3'(c) && wptr[c] == WPW'(k))
          tx_nxt[c][16*k +: 16] = cfg_din & VMASK[16*k +: 16];
      end
    end
  end

  always_comb begin
    rd_word = '0;
    for (int c = 0; c < NCHAIN; c++)
      for (int k = 0; k < NWORD; k++)
        if (rchain == 3'(c) && rword == WPW'(k))
          rd_word = rx[c][16*k +: 16];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      sr_clk   <= 1'b0;
      sr_dout  <= '0;
      sr_load  <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rchain   <= '0;
      rword    <= '0;
      div_q    <= '0;
      div_cnt  <= '0;
      phase    <= 1'b0;
      bit_cnt  <= '0;
      for (int c = 0; c < NCHAIN; c++) begin
        tx[c]   <= '0;
        rx[c]   <= '0;
        wptr[c] <= '0;
      end
    end else begin
      rd_valid <= 1'b0;
      for (int c = 0; c < NCHAIN; c++)
        tx[c] <= tx_nxt[c];
      case (state)
        IDLE: begin
          for (int c = 0; c < NCHAIN; c++)
            if (cfg_wr_en && cfg_sel == 3'(c) && wptr[c] != WPW'(NWORD - 1))
              wptr[c] <= wptr[c] + 1'b1;
          if (rd_en) begin
            rd_valid <= 1'b1;
            rd_data  <= rd_word;
            if (rword == WPW'(NWORD - 1)) begin
              rword  <= '0;
              rchain <= (rchain == 3'(NCHAIN - 1)) ? 3'd0 : rchain + 3'd1;
            end else begin
              rword <= rword + 1'b1;
            end
          end
          if (start) begin
            state   <= SHIFT;
            busy    <= 1'b1;
            div_q   <= div;
            div_cnt <= '0;
            phase   <= 1'b0;
            bit_cnt <= '0;
            sr_clk  <= 1'b0;
            for (int c = 0; c < NCHAIN; c++)
              sr_dout[c] <= tx_nxt[c][bit_idx('0)];
          end
        end
        SHIFT: begin
          div_cnt <= tick ? '0 : div_cnt + 1'b1;
          if (tick) begin
            if (!phase) begin
              sr_clk <= 1'b1;
              phase  <= 1'b1;
            end else begin
              sr_clk  <= 1'b0;
              phase   <= 1'b0;
              bit_cnt <= bit_cnt + 1'b1;
              for (int c = 0; c < NCHAIN; c++)
                rx[c][bit_idx(bit_cnt)] <= sr_din[c];
              if (bit_cnt == LAST_BIT) begin
                state   <= LOAD;
                sr_load <= 1'b1;
                sr_dout <= '0;
              end else begin
                for (int c = 0; c < NCHAIN; c++)
                  sr_dout[c] <= tx[c][bit_idx(bit_cnt + 1'b1)];
              end
            end
          end
        end
        LOAD: begin
          div_cnt <= tick ? '0 : div_cnt + 1'b1;
          if (tick) begin
            sr_load <= 1'b0;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= FIN;
            rchain  <= '0;
            rword   <= '0;
            for (int c = 0; c < NCHAIN; c++)
              wptr[c] <= '0;
          end
        end
        FIN: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sr_multi_rw.sv
`timescale 1ns/1ps
// Bench for sr_multi_rw: random config traffic through a chip shift-register model,
// checked against a word-level model of TX, chip contents and readback.
module tb_sr_multi_rw;
  localparam int W  = 170;
  localparam int NC = 2;
  localparam int NW = 11;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  div;
  logic        cfg_wr_en, start, rd_en;
  logic [2:0]  cfg_sel;
  logic [15:0] cfg_din;
  logic        busy, done, sr_clk, sr_load, rd_valid;
  logic [1:0]  sr_dout, sr_din;
  logic [15:0] rd_data;

  logic [5:0]  b_div;
  logic        b_cfg_wr_en, b_start, b_rd_en;
  logic [2:0]  b_cfg_sel;
  logic [15:0] b_cfg_din;
  logic        b_busy, b_done, b_sr_clk, b_sr_load, b_rd_valid;
  logic [0:0]  b_sr_dout, b_sr_din;
  logic [15:0] b_rd_data;

  always #5 clk = ~clk;
  assign b_sr_din = 1'b0;

  sr_multi_rw u_dut (
    .clk(clk), .rst(rst), .div(div), .cfg_wr_en(cfg_wr_en), .cfg_sel(cfg_sel), .cfg_din(cfg_din),
    .start(start), .busy(busy), .done(done), .sr_clk(sr_clk), .sr_dout(sr_dout), .sr_din(sr_din),
    .sr_load(sr_load), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid)
  );

  sr_multi_rw #(.WIDTH(W), .NCHAIN(1), .SHIFT_DIRECTION(0)) u_dut1 (
    .clk(clk), .rst(rst), .div(b_div), .cfg_wr_en(b_cfg_wr_en), .cfg_sel(b_cfg_sel), .cfg_din(b_cfg_din),
    .start(b_start), .busy(b_busy), .done(b_done), .sr_clk(b_sr_clk), .sr_dout(b_sr_dout), .sr_din(b_sr_din),
    .sr_load(b_sr_load), .rd_en(b_rd_en), .rd_data(b_rd_data), .rd_valid(b_rd_valid)
  );

  // Chip: W-bit shift register per chain; output bit is registered on the rising shift clock.
  logic [W-1:0] chip [NC];
  logic         chip_clr;
  always @(posedge sr_clk or posedge chip_clr) begin
    if (chip_clr) begin
      for (int c = 0; c < NC; c++) chip[c] <= '0;
      sr_din <= '0;
    end else begin
      for (int c = 0; c < NC; c++) begin
        sr_din[c] <= chip[c][W-1];
        chip[c]   <= {chip[c][W-2:0], sr_dout[c]};
      end
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [15:0] tx_m   [NC][NW];
  logic [15:0] chip_m [NC][NW];
  logic [15:0] rx_m   [NC][NW];
  int          wp_m   [NC];

  function automatic logic [15:0] wmask(input int k);
    int n;
    n = W - 16 * k;
    return (n >= 16) ? 16'hFFFF : 16'((1 << n) - 1);
  endfunction

  task automatic m_reset();
    for (int c = 0; c < NC; c++) begin
      wp_m[c] = 0;
      for (int k = 0; k < NW; k++) begin
        tx_m[c][k] = '0; chip_m[c][k] = '0; rx_m[c][k] = '0;
      end
    end
  endtask

  task automatic m_write(input int c, input logic [15:0] d);
    if (c < NC) begin
      tx_m[c][wp_m[c]] = d & wmask(wp_m[c]);
      if (wp_m[c] < NW - 1) wp_m[c]++;
    end
  endtask

  // A completed cycle returns the chip's old contents and leaves TX in the chip.
  task automatic m_finish();
    for (int c = 0; c < NC; c++) begin
      wp_m[c] = 0;
      for (int k = 0; k < NW; k++) begin
        rx_m[c][k]   = chip_m[c][k];
        chip_m[c][k] = tx_m[c][k];
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int c, input logic [15:0] d);
    cfg_wr_en = 1'b1; cfg_sel = 3'(c); cfg_din = d;
    cyc();
    cfg_wr_en = 1'b0;
    m_write(c, d);
  endtask

  task automatic readback(input int n);
    int rc, rw;
    rc = 0; rw = 0;
    rd_en = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (i == n - 1) begin
        cyc();
        rd_en = 1'b0;
      end else begin
        cyc();
      end
      check($sformatf("rd_valid_%0d", i), rd_valid, 1);
      check($sformatf("rd_c%0dw%0d", rc, rw), rd_data, rx_m[rc][rw]);
      if (rw == NW - 1) begin rw = 0; rc = (rc == NC - 1) ? 0 : rc + 1; end
      else rw++;
    end
    cyc();
    check("rd_valid_idle", rd_valid, 0);
  endtask

  task automatic run(input int dv, input bit inj, input bit cw, input int csel, input logic [15:0] cd);
    int k, rises, loads, busyc, extra, bound;
    bit pc, seen;
    logic [175:0] pad;
    bound = 1 + ((2 * W + 1) << dv) + 8;
    div = 6'(dv);
    start = 1'b1;
    if (cw) begin cfg_wr_en = 1'b1; cfg_sel = 3'(csel); cfg_din = cd; end
    cyc();
    start = 1'b0; cfg_wr_en = 1'b0;
    div = 6'($urandom_range(0, 63));
    if (cw) m_write(csel, cd);
    check("busy_rise", busy, 1);
    check("dout_first", sr_dout, {tx_m[1][NW-1][9], tx_m[0][NW-1][9]});
    k = 1; rises = 0; loads = 0; busyc = 0; seen = 0; pc = 0;
    while (!seen && k < bound) begin
      if (busy) busyc++;
      if (sr_load) loads++;
      if (sr_clk && !pc) rises++;
      pc = sr_clk;
      if (done) seen = 1;
      else begin
        if (inj && k == 5) begin
          start = 1'b1; cfg_wr_en = 1'b1; cfg_sel = 3'd0; cfg_din = 16'($urandom); rd_en = 1'b1;
        end
        cyc();
        k++;
        if (inj && k == 6) begin
          check("rd_while_busy", rd_valid, 0);
          start = 1'b0; cfg_wr_en = 1'b0; rd_en = 1'b0;
        end
      end
    end
    check("done_lat", k, 1 + ((2 * W + 1) << dv));
    check("busy_at_done", busy, 0);
    check("sclk_rises", rises, W);
    check("load_clks", loads, 1 << dv);
    check("busy_clks", busyc, (2 * W + 1) << dv);
    extra = 0;
    repeat (4) begin
      cyc();
      if (done || busy) extra++;
    end
    check("post_done_quiet", extra, 0);
    for (int c = 0; c < NC; c++) begin
      pad = 176'(chip[c]);
      for (int j = 0; j < NW; j++)
        check($sformatf("chip_c%0dw%0d", c, j), pad[16*j +: 16], tx_m[c][j]);
    end
    m_finish();
  endtask

  initial begin
    int s, n, bk, bcnt, blast, bload, bbusy;
    bit bseen;
    rst = 1'b0; chip_clr = 1'b0;
    div = '0; cfg_wr_en = 1'b0; cfg_sel = '0; cfg_din = '0; start = 1'b0; rd_en = 1'b0;
    b_div = '0; b_cfg_wr_en = 1'b0; b_cfg_sel = '0; b_cfg_din = '0; b_start = 1'b0; b_rd_en = 1'b0;
    m_reset();
    #1;
    rst = 1'b1; chip_clr = 1'b1;
    #1;
    chip_clr = 1'b0;
    cyc(); cyc();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sr_clk", sr_clk, 0);
    check("rst_sr_dout", sr_dout, 0);
    check("rst_sr_load", sr_load, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_valid", rd_valid, 0);
    rst = 1'b0;
    cyc();

    // Directed first pass: fixed patterns, zero readback, then wraparound.
    for (int k = 0; k < NW; k++) begin
      wr(0, 16'hA5A5);
      wr(1, 16'(k + 1));
    end
    run(0, 0, 0, 0, '0);
    readback(2 * NW + 1);
    // Second pass with start/write/read poked while busy; readback returns the TX just sent.
    run(0, 1, 0, 0, '0);
    readback(2 * NW);

    // Random traffic, including invalid selects, saturation and a write coincident with start.
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(0, 26);
      for (int i = 0; i < n; i++) begin
        s = ($urandom_range(0, 4) == 4) ? $urandom_range(2, 7) : $urandom_range(0, 1);
        wr(s, 16'($urandom));
      end
      run($urandom_range(0, 2), 0, r == 1, $urandom_range(0, 1), 16'($urandom));
      readback(2 * NW);
    end

    // Reset in the middle of SHIFT, then a clean cycle.
    wr(0, 16'($urandom));
    wr(1, 16'($urandom));
    div = '0; start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (101) cyc();
    check("pre_rst_busy", busy, 1);
    check("pre_rst_sr_clk", sr_clk, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_sr_clk", sr_clk, 0);
    check("mid_rst_sr_dout", sr_dout, 0);
    check("mid_rst_sr_load", sr_load, 0);
    check("mid_rst_done", done, 0);
    cyc();
    rst = 1'b0; chip_clr = 1'b1;
    #1 chip_clr = 1'b0;
    m_reset();
    for (int i = 0; i < 5; i++) begin
      wr(0, 16'($urandom));
      wr(1, 16'($urandom));
    end
    run(0, 0, 0, 0, '0);
    readback(2 * NW);

    // Single-chain LSB-first instance, div=3, only bit 0 set.
    b_cfg_wr_en = 1'b1; b_cfg_sel = 3'd0; b_cfg_din = 16'h0001;
    cyc();
    b_cfg_wr_en = 1'b0;
    b_div = 6'd3; b_start = 1'b1;
    cyc();
    b_start = 1'b0;
    bk = 1; bcnt = 0; blast = 0; bload = 0; bbusy = 0; bseen = 0;
    while (!bseen && bk < 3000) begin
      if (b_sr_dout[0]) begin bcnt++; blast = bk; end
      if (b_sr_load) bload++;
      if (b_busy) bbusy++;
      if (b_done) bseen = 1;
      else begin cyc(); bk++; end
    end
    check("b_done_lat", bk, 1 + 341 * 8);
    check("b_dout_clks", bcnt, 16);
    check("b_dout_last", blast, 16);
    check("b_load_clks", bload, 8);
    check("b_busy_clks", bbusy, 341 * 8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
